// File: rtl/piso_shift_tx.sv
// piso_shift_tx -- parallel-in serial-out shift transmitter.
//
// Accepts a WIDTH-bit word through a valid/ready handshake and presents it
// one bit per SHIFT_EN strobe on SDO. The first bit appears on SDO at the
// same edge that captures the word.
//
// Build option:
//   PISO_PARITY_EN  when defined, an even-parity bit (XOR of the captured
//                   word) follows the data bits as bit index WIDTH, making
//                   the frame WIDTH+1 bits long.
//
// Ports:
//   CLK1        in   system clock, rising edge
//   RST         in   synchronous active-high reset
//   LOAD_VALID  in   word on LOAD_DATA is offered
//   LOAD_DATA   in   parallel word to transmit
//   LOAD_READY  out  word can be accepted (high only in IDLE)
//   DIR         in   0 = MSB-first, 1 = LSB-first, sampled at load
//   SHIFT_EN    in   step strobe, one bit per high cycle
//   SDO         out  registered serial data
//   BUSY        out  frame in progress
//   DONE        out  one-cycle pulse after the last bit is consumed
//   BIT_CNT     out  index of the bit currently on SDO (0 in IDLE)
module piso_shift_tx #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                       CLK1,
    input  logic                       RST,
    input  logic                       LOAD_VALID,
    input  logic [WIDTH-1:0]           LOAD_DATA,
    output logic                       LOAD_READY,
    input  logic                       DIR,
    input  logic                       SHIFT_EN,
    output logic                       SDO,
    output logic                       BUSY,
    output logic                       DONE,
    output logic [$clog2(WIDTH+2)-1:0] BIT_CNT
);

    localparam int unsigned CW = $clog2(WIDTH + 2);

`ifdef PISO_PARITY_EN
    localparam int unsigned FRAME_LEN = WIDTH + 1;
    localparam logic [CW-1:0] DATA_LAST = CW'(WIDTH - 1);
`else
    localparam int unsigned FRAME_LEN = WIDTH;
`endif
    localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] sreg;
    logic             dir_q;
    logic             sdo_q;
    logic             busy_q;
    logic             done_q;
    logic [CW-1:0]    cnt;
    logic             next_bit;
`ifdef PISO_PARITY_EN
    logic             parity_q;
`endif

    // The bit that follows the one currently on SDO. The shift register
    // still holds the current bit at its output end, so the next one sits
    // one position inward.
    always_comb begin
        next_bit = dir_q ? sreg[1] : sreg[WIDTH-2];
`ifdef PISO_PARITY_EN
        if (cnt == DATA_LAST) begin
            next_bit = parity_q;
        end
`endif
    end

    always_ff @(posedge CLK1) begin
        if (RST) begin
            state  <= ST_IDLE;
            sreg   <= '0;
            dir_q  <= 1'b0;
            sdo_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            cnt    <= '0;
`ifdef PISO_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // A load takes priority over any SHIFT_EN in the same cycle.
                    if (LOAD_VALID) begin
                        state  <= ST_SHIFT;
                        sreg   <= LOAD_DATA;
                        dir_q  <= DIR;
                        sdo_q  <= DIR ? LOAD_DATA[0] : LOAD_DATA[WIDTH-1];
                        busy_q <= 1'b1;
                        cnt    <= '0;
`ifdef PISO_PARITY_EN
                        parity_q <= ^LOAD_DATA;
`endif
                    end
                end
                ST_SHIFT: begin
                    if (SHIFT_EN) begin
                        if (cnt == LAST) begin
                            state  <= ST_IDLE;
                            sreg   <= '0;
                            sdo_q  <= 1'b0;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            cnt    <= '0;
                        end else begin
                            sreg  <= dir_q ? (sreg >> 1) : (sreg << 1);
                            sdo_q <= next_bit;
                            cnt   <= cnt + CW'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign LOAD_READY = (state == ST_IDLE);
    assign SDO        = sdo_q;
    assign BUSY       = busy_q;
    assign DONE       = done_q;
    assign BIT_CNT    = cnt;

endmodule

// File: tb/tb_piso_shift_tx.sv
// tb_piso_shift_tx -- self-checking bench for piso_shift_tx (WIDTH=8).
// Table of frames with hand-computed send order, plus hand-written
// sequences for reset mid-frame, back-to-back load in the DONE cycle and
// SHIFT_EN while idle. Honours PISO_PARITY_EN for the frame length.
module tb_piso_shift_tx;

    localparam int unsigned WIDTH = 8;
`ifdef PISO_PARITY_EN
    localparam int unsigned NB = 9;
`else
    localparam int unsigned NB = 8;
`endif

    logic             CLK1 = 1'b0;
    logic             RST = 1'b0;
    logic             LOAD_VALID = 1'b0;
    logic [WIDTH-1:0] LOAD_DATA = '0;
    logic             LOAD_READY;
    logic             DIR = 1'b0;
    logic             SHIFT_EN = 1'b0;
    logic             SDO;
    logic             BUSY;
    logic             DONE;
    logic [3:0]       BIT_CNT;

    int unsigned checks = 0;
    int unsigned errors = 0;

    piso_shift_tx #(.WIDTH(WIDTH)) dut (
        .CLK1       (CLK1),
        .RST        (RST),
        .LOAD_VALID (LOAD_VALID),
        .LOAD_DATA  (LOAD_DATA),
        .LOAD_READY (LOAD_READY),
        .DIR        (DIR),
        .SHIFT_EN   (SHIFT_EN),
        .SDO        (SDO),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .BIT_CNT    (BIT_CNT)
    );

    always #5 CLK1 = ~CLK1;

    typedef struct {
        logic [7:0] data;       // word loaded
        logic       dir;        // DIR at load
        logic [7:0] exp;        // expected bits in send order, bit 7 first
        logic       par;        // expected parity bit (parity build only)
        bit         toggle;     // flip DIR after 3 strobes
        bit         inject;     // offer 8'hFF after 3 strobes
        bit         with_shift; // SHIFT_EN high together with the load
        bit         hold;       // keep LOAD_VALID high into the DONE cycle
        logic [7:0] next;       // word offered when hold is set
        bit         preloaded;  // frame already loaded by the caller
    } vec_t;

    vec_t vecs [5];

    task automatic step();
        @(posedge CLK1);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_frame(input vec_t v);
        logic expbit;
        if (!v.preloaded) begin
            LOAD_VALID = 1'b1;
            LOAD_DATA  = v.data;
            DIR        = v.dir;
            SHIFT_EN   = v.with_shift;
            step();
            LOAD_VALID = 1'b0;
            SHIFT_EN   = 1'b0;
        end
        chk("busy_after_load", 32'(BUSY), 32'd1);
        chk("ready_after_load", 32'(LOAD_READY), 32'd0);
        for (int unsigned i = 0; i < NB; i++) begin
            expbit = (i < 8) ? v.exp[7-i] : v.par;
            chk("sdo", 32'(SDO), 32'(expbit));
            chk("bit_cnt", 32'(BIT_CNT), 32'(i));
            if (v.toggle && i == 3) DIR = ~DIR;
            if (v.inject && i == 3) begin
                LOAD_VALID = 1'b1;
                LOAD_DATA  = 8'hFF;
                step();
                chk("ready_in_shift", 32'(LOAD_READY), 32'd0);
                chk("sdo_hold_on_ignored_load", 32'(SDO), 32'(expbit));
                chk("cnt_hold_on_ignored_load", 32'(BIT_CNT), 32'(i));
                LOAD_VALID = 1'b0;
            end
            SHIFT_EN = 1'b1;
            if (i == NB - 1 && v.hold) begin
                LOAD_VALID = 1'b1;
                LOAD_DATA  = v.next;
                DIR        = 1'b0;
            end
            step();
            SHIFT_EN = 1'b0;
            if (i < NB - 1) begin
                chk("no_early_done", 32'(DONE), 32'd0);
                step();
            end
        end
        chk("done_pulse", 32'(DONE), 32'd1);
        chk("busy_clear", 32'(BUSY), 32'd0);
        chk("sdo_clear", 32'(SDO), 32'd0);
        chk("cnt_clear", 32'(BIT_CNT), 32'd0);
        chk("ready_set", 32'(LOAD_READY), 32'd1);
        if (!v.hold) begin
            step();
            chk("done_one_cycle", 32'(DONE), 32'd0);
        end
    endtask

    initial begin
        vec_t v;
        //         data   dir   exp    par   tog  inj  wsh  hold next   pre
        vecs[0] = '{8'h0F, 1'b0, 8'h0F, 1'b0, 0,   0,   0,   0,   8'h00, 0};
        vecs[1] = '{8'h0F, 1'b1, 8'hF0, 1'b0, 1,   0,   0,   0,   8'h00, 0};
        vecs[2] = '{8'hA5, 1'b0, 8'hA5, 1'b0, 0,   1,   0,   0,   8'h00, 0};
        vecs[3] = '{8'hB2, 1'b1, 8'h4D, 1'b0, 0,   0,   1,   0,   8'h00, 0};
        vecs[4] = '{8'h01, 1'b1, 8'h80, 1'b1, 0,   0,   0,   0,   8'h00, 0};

        // Reset from unknown state
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk("rst_sdo", 32'(SDO), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        chk("rst_ready", 32'(LOAD_READY), 32'd1);
        chk("rst_cnt", 32'(BIT_CNT), 32'd0);

        // SHIFT_EN while idle is ignored
        SHIFT_EN = 1'b1;
        step();
        SHIFT_EN = 1'b0;
        chk("idle_shift_busy", 32'(BUSY), 32'd0);
        chk("idle_shift_cnt", 32'(BIT_CNT), 32'd0);
        chk("idle_shift_done", 32'(DONE), 32'd0);
        chk("idle_shift_sdo", 32'(SDO), 32'd0);

        for (int unsigned k = 0; k < 5; k++) begin
            run_frame(vecs[k]);
            step();
        end

        // Reset mid-frame: C3 MSB-first, abort after 4 strobes
        LOAD_VALID = 1'b1;
        LOAD_DATA  = 8'hC3;
        DIR        = 1'b0;
        step();
        LOAD_VALID = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            SHIFT_EN = 1'b1;
            step();
            SHIFT_EN = 1'b0;
            step();
        end
        chk("pre_abort_cnt", 32'(BIT_CNT), 32'd4);
        chk("pre_abort_sdo", 32'(SDO), 32'd0);
        RST      = 1'b1;
        SHIFT_EN = 1'b1;
        step();
        RST      = 1'b0;
        SHIFT_EN = 1'b0;
        chk("abort_busy", 32'(BUSY), 32'd0);
        chk("abort_done", 32'(DONE), 32'd0);
        chk("abort_ready", 32'(LOAD_READY), 32'd1);
        chk("abort_cnt", 32'(BIT_CNT), 32'd0);
        chk("abort_sdo", 32'(SDO), 32'd0);
        step();
        chk("abort_no_done", 32'(DONE), 32'd0);
        v = '{8'h81, 1'b0, 8'h81, 1'b0, 0, 0, 0, 0, 8'h00, 0};
        run_frame(v);
        step();

        // Back-to-back: 55 with LOAD_VALID held into the DONE cycle, 07 next
        v = '{8'h55, 1'b0, 8'h55, 1'b0, 0, 0, 0, 1, 8'h07, 0};
        run_frame(v);
        step();
        LOAD_VALID = 1'b0;
        chk("b2b_done_drop", 32'(DONE), 32'd0);
        chk("b2b_busy", 32'(BUSY), 32'd1);
        chk("b2b_done_busy_excl", 32'(DONE & BUSY), 32'd0);
        v = '{8'h07, 1'b0, 8'h07, 1'b1, 0, 0, 0, 0, 8'h00, 1};
        run_frame(v);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
